muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_unit_negate.sv | 12 +
 rtl/muldiv_unit.sv | 121 ++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op and FSM state encodings for the multiply/divide unit and the decoder
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10
   } state_e;

   function automatic logic op_signed(input op_e op);
      return op == OP_MULT || op == OP_DIV;
   endfunction

   function automatic logic op_div(input op_e op);
      return op == OP_DIVU || op == OP_DIV;
   endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// muldiv_negate: conditional two's-complement negator
//   neg_i : negate when 1, pass through when 0
//   val_i : input value, res_o : result
module muldiv_negate #(
   parameter int size = 32
) (
   input  logic            neg_i,
   input  logic [size-1:0] val_i,
   output logic [size-1:0] res_o
);
   assign res_o = neg_i ? ~val_i + 1'b1 : val_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULTU/MULT/DIVU/DIV unit, one bit per cycle, result in hi_o/lo_o
//   clk_i, rst_i (async active-low) : clock and reset
//   start_i, op_i, src1_i, src2_i   : request, sampled only while idle
//   busy_o, done_o                  : operation in progress / one-cycle completion pulse
//   hi_o, lo_o                      : product halves, or remainder / quotient
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [size-1:0] src1_i,
   input  logic [size-1:0] src2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [size-1:0] hi_o,
   output logic [size-1:0] lo_o
);
   localparam int CW = $clog2(size) + 1;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [size-1:0]   m_q, m_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              done_q, done_d, sgn_q, sgn_d, rsgn_q, rsgn_d;
   op_e               op_in;
   logic              sgn_in, is_div, fits;
   logic [size-1:0]   abs1, abs2, quo, rem;
   logic [2*size-1:0] prod;
   logic [size:0]     sum, rs;

   assign op_in  = op_e'(op_i);
   assign sgn_in = op_signed(op_in);
   assign is_div = op_div(op_q);
   assign busy_o = state_q != ST_IDLE;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

   muldiv_negate #(.size(size)) u_abs1 (.neg_i(sgn_in & src1_i[size-1]), .val_i(src1_i), .res_o(abs1));
   muldiv_negate #(.size(size)) u_abs2 (.neg_i(sgn_in & src2_i[size-1]), .val_i(src2_i), .res_o(abs2));
   muldiv_negate #(.size(2*size)) u_prod (.neg_i(sgn_q), .val_i({acc_hi_q, acc_lo_q}), .res_o(prod));
   muldiv_negate #(.size(size)) u_quo (.neg_i(sgn_q), .val_i(acc_lo_q), .res_o(quo));
   muldiv_negate #(.size(size)) u_rem (.neg_i(rsgn_q), .val_i(acc_hi_q), .res_o(rem));

   // multiply: add multiplicand when the multiplier LSB is set, then shift {carry,hi,lo} right
   assign sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
   // divide: shift {rem,quo} left and keep the trial subtraction when it does not borrow
   assign rs   = {acc_hi_q, acc_lo_q[size-1]};
   assign fits = rs >= {1'b0, m_q};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      m_d      = m_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      sgn_d    = sgn_q;
      rsgn_d   = rsgn_q;
      case (state_q)
         ST_IDLE: if (start_i) begin
            state_d  = ST_CALC;
            op_d     = op_in;
            cnt_d    = '0;
            acc_hi_d = '0;
            m_d      = op_div(op_in) ? abs2 : abs1;
            acc_lo_d = op_div(op_in) ? abs1 : abs2;
            // a zero divisor must leave the all-ones quotient un-negated
            sgn_d    = sgn_in & (src1_i[size-1] ^ src2_i[size-1]) & ~(op_div(op_in) & (src2_i == '0));
            rsgn_d   = sgn_in & src1_i[size-1];
         end
         ST_CALC: begin
            cnt_d    = cnt_q + 1'b1;
            acc_hi_d = is_div ? (fits ? rs[size-1:0] - m_q : rs[size-1:0]) : sum[size:1];
            acc_lo_d = is_div ? {acc_lo_q[size-2:0], fits} : {sum[0], acc_lo_q[size-1:1]};
            if (cnt_q == CW'(size - 1)) state_d = ST_FIXUP;
         end
         ST_FIXUP: begin
            {hi_d, lo_d} = is_div ? {rem, quo} : prod;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MULTU;
         m_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         sgn_q    <= 1'b0;
         rsgn_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         m_q      <= m_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         sgn_q    <= sgn_d;
         rsgn_q   <= rsgn_d;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit
module tb_muldiv_unit;
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, start, busy, done;
   logic [1:0]  op;
   logic [31:0] s1, s2, hi, lo;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        exp_q[$];
   exp_t        done_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_unit #(.size(32)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op), .src1_i(s1), .src2_i(s2),
      .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int     sa, sd;
      sa = a;
      sd = b;
      case (o)
         2'b00: return {32'b0, a} * {32'b0, b};
         2'b01: begin
            p = longint'(sa) * longint'(sd);
            return p;
         end
         2'b10: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sa % sd), 32'(sa / sd)};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         chk("busy_during_done", {63'b0, busy}, 64'd0);
         if (exp_q.size() == 0) chk("spurious_done", {63'b0, done}, 64'd0);
         else begin
            done_e = exp_q.pop_front();
            chk("hi", {32'b0, hi}, {32'b0, done_e.hi});
            chk("lo", {32'b0, lo}, {32'b0, done_e.lo});
            chk("latency", 64'(cyc - done_e.acc), 64'd33);
         end
      end
   end

   // called just after a falling edge; returns just after the falling edge following the accept
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      start = 1'b1;
      op    = o;
      s1    = a;
      s2    = b;
      {e.hi, e.lo} = model(o, a, b);
      @(posedge clk);
      #1;
      e.acc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op    = 2'($urandom);
      s1    = $urandom;
      s2    = $urandom;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      @(negedge clk);
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!done) chk("timeout", {63'b0, done}, 64'd1);
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      issue(o, a, b);
      wait_done();
      @(negedge clk);
   endtask

   initial begin
      int t1;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      s1    = '0;
      s2    = '0;
      done_e = '{hi: 32'h0, lo: 32'h0, acc: 0};
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_hi", {32'b0, hi}, 64'd0);
      chk("rst_lo", {32'b0, lo}, 64'd0);
      rst_n = 1'b1;
      run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(2'b01, -32'sd7, 32'd3);
      run(2'b11, -32'sd7, 32'd2);
      run(2'b10, 32'd100, 32'd0);
      run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      run(2'b11, -32'sd100, 32'd0);
      run(2'b01, 32'h8000_0000, 32'h8000_0000);
      run(2'b11, 32'd7, -32'sd2);
      // start pulses mid-operation must be ignored; outputs hold the previous result during CALC
      issue(2'b00, 32'd1234, 32'd5678);
      repeat (4) @(negedge clk);
      start = 1'b1;
      op    = 2'b11;
      s1    = 32'd999;
      s2    = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("hold_hi", {32'b0, hi}, {32'b0, done_e.hi});
      chk("hold_lo", {32'b0, lo}, {32'b0, done_e.lo});
      chk("busy_calc", {63'b0, busy}, 64'd1);
      repeat (10) @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      s1    = 32'd42;
      s2    = 32'd42;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);
      // back-to-back: start held through the done cycle
      issue(2'b10, 32'd1000, 32'd7);
      wait_done();
      t1 = cyc;
      issue(2'b01, 32'd12345, -32'sd678);
      wait_done();
      chk("b2b_gap", 64'(cyc - t1), 64'd34);
      @(negedge clk);
      // asynchronous reset in the middle of CALC
      issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_hi", {32'b0, hi}, 64'd0);
      chk("abort_lo", {32'b0, lo}, 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run(2'b10, 32'd1000, 32'd7);
      repeat (10) run(2'($urandom), pick(), pick());
      if (exp_q.size() != 0) chk("pending", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
